ram_16x8_bist: RTL
==================

# ram_16x8_bist

Built-in self-test controller that drives the 16x8 single-port RAM through its address/data/write port, runs a March-style write/read/compare sequence, and reports pass/fail. It sits between the top-level test control logic and the RAM instance, and is the initiator side of the RAM port. It owns ram_addr, ram_din and ram_we while the test runs, and consumes ram_dout.

## Interface
- ADDR_W, 4, RAM address width
- DATA_W, 8, RAM data width
- DEPTH, 16, number of RAM words tested (2**ADDR_W)
- PATTERN, 8'hAA, background data pattern P; ~P is its bitwise complement
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- start  input  1  begin test; sampled only in IDLE or DONE
- busy  output  1  high while test sequence runs
- done  output  1  sticky high after completion until next start or reset
- fail  output  1  sticky high once any compare mismatches
- fail_addr  output  ADDR_W  address of first mismatch
- fail_data  output  DATA_W  ram_dout value at first mismatch
- err_cnt  output  6  total mismatches in current run
- ram_addr  output  ADDR_W  RAM address
- ram_din  output  DATA_W  RAM write data
- ram_we  output  1  RAM write enable
- ram_dout  input  DATA_W  RAM read data, registered: valid the cycle after ram_addr is presented

## Operation
- All outputs are registered.
- Reset value of every output is 0; the state machine goes to IDLE.
- States:
  - IDLE
  - M0: ascending, write P
  - M1: ascending, read expecting P, then write ~P
  - M2: descending, read expecting ~P, then write P
  - M3: descending, read expecting P
  - DONE
- M0 uses one cycle per address: ram_we=1, ram_din=P, ram_addr 0..15.
- M1, M2 and M3 use two sub-phases per address:
  - RD: ram_we=0, ram_din=0, ram_addr=a.
  - CMP: same ram_addr=a; compare ram_dout against the expected value.
  - In M1/M2, CMP also drives ram_we=1, ram_din=new value. In M3, CMP keeps ram_we=0.
- Element transitions:
  - M0 ends after address 15 → M1 starting at address 0.
  - M1 ends after CMP at address 15 → M2 starting at address 15.
  - M2 ends after CMP at address 0 → M3 starting at address 15.
  - M3 ends after CMP at address 0 → DONE.
- On a mismatch in CMP:
  - err_cnt increments by 1. Maximum possible count is 48, so there is no saturation.
  - If fail=0: set fail=1 and capture fail_addr=a, fail_data=ram_dout.
  - If fail=1 already, later mismatches do not update fail_addr or fail_data.
  - The test always runs to completion; mismatches never abort it.
- start behaviour:
  - start=1 in IDLE or DONE clears done, fail, fail_addr, fail_data and err_cnt, then enters M0.
  - start is ignored while busy, including when it is held high.
- DONE: busy=0, done=1, ram_we=0; results are held.

## Timing
- Edge E0 samples start=1. The first M0 write cycle follows E0: busy=1, ram_addr=0, ram_we=1, ram_din=P.
- Busy duration: exactly 16 + 32 + 32 + 32 = 112 cycles. At the 112th edge after E0, busy falls and done rises in the same cycle.
- Compare is evaluated at the edge that ends CMP, using ram_dout read by the edge that ended RD.
- Write in CMP commits at that same edge. Read precedes write at each address.
- Address wrap: the address counter never wraps. Element boundaries are detected at 15 (ascending) and 0 (descending).
- Reset low mid-run: at the next edge all outputs are 0 and the state is IDLE. No further RAM writes occur. RAM contents are left as-is.
- reset low and start high in the same cycle: reset wins.

## Test plan
- Fault-free RAM model, pulse start → busy high 112 cycles; done=1, fail=0, err_cnt=0; every RAM word reads 8'hAA afterwards.
- Cycle trace after start:
  - Cycles 1-16: ram_we=1, ram_din=8'hAA, ram_addr 0..15.
  - Cycle 17: ram_addr=0, ram_we=0.
  - Cycle 18: ram_addr=0, ram_we=1, ram_din=8'h55.
  - Cycle 49: ram_addr=15, ram_we=0.
- Address 5 bit0 stuck-at-0 → fail=1, fail_addr=4'd5, fail_data=8'h54, err_cnt=1. The mismatch is in M2.
- Address 12 ram_dout forced 8'hFF → fail=1, fail_addr=4'd12, fail_data=8'hFF, err_cnt=3.
- Drive reset=0 at cycle 40 of a run → next edge: busy=0, done=0, ram_we=0, ram_addr=0. A new start then completes fault-free with done=1 after 112 cycles.
- Cases for start:
  - Hold start=1 for the whole run → single 112-cycle run, then an immediate restart from DONE.
  - Start in DONE after a failing run → fail, err_cnt and fail_addr cleared on the first busy cycle.

Source files
------------

// File: rtl/ram_16x8_bist.sv
// ram_16x8_bist
//
// March-style built-in self-test controller for a 16x8 single-port RAM with
// a registered read port. It owns the RAM address/data/write-enable while a
// test runs and checks the returned read data.
//
// March elements:
//   M0  ascending   write P
//   M1  ascending   read expect P,  write ~P
//   M2  descending  read expect ~P, write P
//   M3  descending  read expect P
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous, active-low reset
//   start      in   begin a test (honoured only in IDLE or DONE)
//   busy       out  high while the march sequence runs
//   done       out  sticky completion flag, cleared by start or reset
//   fail       out  sticky mismatch flag
//   fail_addr  out  address of the first mismatch
//   fail_data  out  read data seen at the first mismatch
//   err_cnt    out  number of mismatches in the current run
//   ram_addr   out  RAM address
//   ram_din    out  RAM write data
//   ram_we     out  RAM write enable
//   ram_dout   in   RAM read data, valid the cycle after ram_addr
module ram_16x8_bist #(
  parameter int                 ADDR_W  = 4,
  parameter int                 DATA_W  = 8,
  parameter int                 DEPTH   = 16,
  parameter logic [DATA_W-1:0]  PATTERN = 8'hAA
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data,
  output logic [5:0]        err_cnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_M0,
    S_M1,
    S_M2,
    S_M3,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   w_addr_nxt;
  // r_cmp = 0: read sub-phase, r_cmp = 1: compare (and write-back) sub-phase
  logic                r_cmp;
  logic                w_cmp_nxt;
  logic                w_clear;

  logic                r_busy;
  logic                r_done;
  logic                r_we;
  logic [DATA_W-1:0]   r_din;
  logic                r_fail;
  logic [ADDR_W-1:0]   r_fail_addr;
  logic [DATA_W-1:0]   r_fail_data;
  logic [5:0]          r_err_cnt;

  logic                w_busy_nxt;
  logic                w_done_nxt;
  logic                w_we_nxt;
  logic [DATA_W-1:0]   w_din_nxt;
  logic                w_check;
  logic                w_mismatch;

  // Value the read at the current address must return in this element.
  function automatic logic [DATA_W-1:0] exp_data(input state_t s);
    exp_data = (s == S_M2) ? ~PATTERN : PATTERN;
  endfunction

  // Next state / address / sub-phase
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_cmp_nxt   = r_cmp;
    w_clear     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt = S_M0;
          w_addr_nxt  = ADDR_ZERO;
          w_cmp_nxt   = 1'b0;
          w_clear     = 1'b1;
        end
      end
      S_M0: begin
        if (r_addr == ADDR_LAST) begin
          w_state_nxt = S_M1;
          w_addr_nxt  = ADDR_ZERO;
        end else begin
          w_addr_nxt  = r_addr + ADDR_ONE;
        end
      end
      S_M1: begin
        w_cmp_nxt = ~r_cmp;
        if (r_cmp) begin
          if (r_addr == ADDR_LAST) begin
            w_state_nxt = S_M2;
            w_addr_nxt  = ADDR_LAST;
          end else begin
            w_addr_nxt  = r_addr + ADDR_ONE;
          end
        end
      end
      S_M2: begin
        w_cmp_nxt = ~r_cmp;
        if (r_cmp) begin
          if (r_addr == ADDR_ZERO) begin
            w_state_nxt = S_M3;
            w_addr_nxt  = ADDR_LAST;
          end else begin
            w_addr_nxt  = r_addr - ADDR_ONE;
          end
        end
      end
      S_M3: begin
        w_cmp_nxt = ~r_cmp;
        if (r_cmp) begin
          if (r_addr == ADDR_ZERO) begin
            w_state_nxt = S_DONE;
          end else begin
            w_addr_nxt  = r_addr - ADDR_ONE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_addr_nxt  = ADDR_ZERO;
        w_cmp_nxt   = 1'b0;
      end
    endcase
  end

  // Registered outputs are derived from the state being entered, so the RAM
  // port shows the new address/command in the same cycle as the new state.
  always_comb begin
    w_busy_nxt = (w_state_nxt == S_M0) || (w_state_nxt == S_M1) ||
                 (w_state_nxt == S_M2) || (w_state_nxt == S_M3);
    w_done_nxt = (w_state_nxt == S_DONE);
    w_we_nxt   = 1'b0;
    w_din_nxt  = '0;
    case (w_state_nxt)
      S_M0: begin
        w_we_nxt  = 1'b1;
        w_din_nxt = PATTERN;
      end
      S_M1: begin
        if (w_cmp_nxt) begin
          w_we_nxt  = 1'b1;
          w_din_nxt = ~PATTERN;
        end
      end
      S_M2: begin
        if (w_cmp_nxt) begin
          w_we_nxt  = 1'b1;
          w_din_nxt = PATTERN;
        end
      end
      default: begin
        w_we_nxt  = 1'b0;
        w_din_nxt = '0;
      end
    endcase
  end

  // ram_dout during a compare cycle holds the word read by the edge that
  // ended the read sub-phase at the same address.
  always_comb begin
    w_check    = r_cmp && ((r_state == S_M1) || (r_state == S_M2) ||
                           (r_state == S_M3));
    w_mismatch = w_check && (ram_dout != exp_data(r_state));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_cmp       <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_we        <= 1'b0;
      r_din       <= '0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_data <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_cmp   <= w_cmp_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_we    <= w_we_nxt;
      r_din   <= w_din_nxt;
      if (w_clear) begin
        r_fail      <= 1'b0;
        r_fail_addr <= '0;
        r_fail_data <= '0;
        r_err_cnt   <= '0;
      end else if (w_mismatch) begin
        // At most 48 compares per run, so the 6-bit count cannot overflow.
        r_err_cnt <= r_err_cnt + 6'd1;
        if (!r_fail) begin
          r_fail      <= 1'b1;
          r_fail_addr <= r_addr;
          r_fail_data <= ram_dout;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign fail      = r_fail;
  assign fail_addr = r_fail_addr;
  assign fail_data = r_fail_data;
  assign err_cnt   = r_err_cnt;
  assign ram_addr  = r_addr;
  assign ram_din   = r_din;
  assign ram_we    = r_we;

endmodule
